// File: rtl/main_soc.sv
// Single-cycle RV32I system: unified RAM, 8N1 UART transmitter, 6-bit LED register.
// gp mirrors x3 and exit latches on ECALL so test programs can report pass/fail.
module main_soc #(
  parameter int    MEM_WORDS = 4096,
  parameter string MEM_INIT  = "",
  parameter int    CLK_FREQ  = 27000000,
  parameter int    BAUD      = 115200
) (
  input  logic        clk27MHz,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        exit,
  output logic [5:0]  led,
  output logic [31:0] gp
);
  localparam int          AW       = $clog2(MEM_WORDS);
  localparam logic [31:0] BIT_LAST = 32'(CLK_FREQ / BAUD - 1);

  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
                         OP_BR  = 7'h63, OP_LD    = 7'h03, OP_ST  = 7'h23, OP_IMM  = 7'h13,
                         OP_REG = 7'h33, OP_SYS   = 7'h73;
  localparam logic [31:0] IO_TX = 32'hF000_0000, IO_STAT = 32'hF000_0004, IO_LED = 32'hF000_0008;

  logic [31:0] ram [MEM_WORDS];

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];
  logic [31:0] mepc_q, mtvec_q;
  logic        exit_q;
  logic [5:0]  led_q;
  logic        tx_q, busy_q;
  logic [9:0]  shift_q;
  logic [3:0]  bitn_q;
  logic [31:0] baud_q;

  logic [31:0] instr, rv1, rv2, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opc;
  logic [4:0]  rd, rs1;
  logic [2:0]  f3;

  assign instr = ram[pc_q[AW+1:2]];
  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign rs1   = instr[19:15];
  assign rv1   = rf_q[rs1];
  assign rv2   = rf_q[instr[24:20]];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] fn, input logic alt);
    case (fn)
      3'd0:    alu = alt ? a - b : a + b;
      3'd1:    alu = a << b[4:0];
      3'd2:    alu = {31'b0, $signed(a) < $signed(b)};
      3'd3:    alu = {31'b0, a < b};
      3'd4:    alu = a ^ b;
      3'd5:    alu = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  // Data-side address decode: anything at or above 0xF000_0000 is MMIO, the rest wraps into RAM.
  logic [31:0]   maddr, waddr, mword, io_rd, ld_w, ld_val, wdata;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic [3:0]    wmask;
  logic [AW-1:0] widx;
  logic          is_io, st_ok, ram_we, tx_wr, led_wr;

  assign maddr = rv1 + ((opc == OP_ST) ? imm_s : imm_i);
  assign waddr = {maddr[31:2], 2'b00};
  assign is_io = (maddr[31:28] == 4'hF);
  assign widx  = maddr[AW+1:2];
  assign mword = ram[widx];

  always_comb begin
    io_rd = '0;
    if (waddr == IO_STAT)     io_rd = {31'b0, busy_q};
    else if (waddr == IO_LED) io_rd = {26'b0, led_q};
  end

  assign ld_w = is_io ? io_rd : mword;
  assign ld_b = ld_w[{maddr[1:0], 3'b000} +: 8];
  assign ld_h = maddr[1] ? ld_w[31:16] : ld_w[15:0];

  always_comb begin
    case (f3)
      3'd0:    ld_val = {{24{ld_b[7]}}, ld_b};
      3'd1:    ld_val = {{16{ld_h[15]}}, ld_h};
      3'd4:    ld_val = {24'b0, ld_b};
      3'd5:    ld_val = {16'b0, ld_h};
      default: ld_val = ld_w;
    endcase
  end

  always_comb begin
    case (f3[1:0])
      2'b00:   begin wmask = 4'b0001 << maddr[1:0];            wdata = {4{rv2[7:0]}};  end
      2'b01:   begin wmask = maddr[1] ? 4'b1100 : 4'b0011;     wdata = {2{rv2[15:0]}}; end
      default: begin wmask = 4'b1111;                          wdata = rv2;            end
    endcase
  end

  assign st_ok  = (opc == OP_ST) && (f3 inside {3'd0, 3'd1, 3'd2}) && !exit_q;
  assign ram_we = st_ok && !is_io && rst_n;
  assign tx_wr  = st_ok && is_io && (waddr == IO_TX) && !busy_q;
  assign led_wr = st_ok && is_io && (waddr == IO_LED);

  logic [11:0] csr_a;
  logic [31:0] csr_rd, csr_src, csr_nv;
  logic        csr_op;

  assign csr_a   = instr[31:20];
  assign csr_op  = (opc == OP_SYS) && (f3[1:0] != 2'b00);
  assign csr_src = f3[2] ? {27'b0, rs1} : rv1;

  always_comb begin
    csr_rd = '0;
    if (csr_a == 12'h341)      csr_rd = mepc_q;
    else if (csr_a == 12'h305) csr_rd = mtvec_q;
    case (f3[1:0])
      2'b01:   csr_nv = csr_src;
      2'b10:   csr_nv = csr_rd | csr_src;
      default: csr_nv = csr_rd & ~csr_src;
    endcase
  end

  logic br_take;
  always_comb begin
    case (f3)
      3'd0:    br_take = (rv1 == rv2);
      3'd1:    br_take = (rv1 != rv2);
      3'd4:    br_take = ($signed(rv1) <  $signed(rv2));
      3'd5:    br_take = ($signed(rv1) >= $signed(rv2));
      3'd6:    br_take = (rv1 <  rv2);
      3'd7:    br_take = (rv1 >= rv2);
      default: br_take = 1'b0;
    endcase
  end

  logic        rd_we, csr_we, do_ecall;
  logic [31:0] rd_val;

  always_comb begin
    pc_d     = pc_q + 32'd4;
    rd_we    = 1'b0;
    rd_val   = '0;
    csr_we   = 1'b0;
    do_ecall = 1'b0;
    case (opc)
      OP_LUI:   begin rd_we = 1'b1; rd_val = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; rd_val = pc_q + imm_u; end
      OP_JAL:   begin rd_we = 1'b1; rd_val = pc_q + 32'd4; pc_d = pc_q + imm_j; end
      OP_JALR:  if (f3 == 3'd0) begin
                  rd_we = 1'b1; rd_val = pc_q + 32'd4; pc_d = (rv1 + imm_i) & ~32'd1;
                end
      OP_BR:    if (br_take) pc_d = pc_q + imm_b;
      OP_LD:    if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin rd_we = 1'b1; rd_val = ld_val; end
      OP_IMM:   begin rd_we = 1'b1; rd_val = alu(rv1, imm_i, f3, (f3 == 3'd5) && instr[30]); end
      OP_REG:   if (instr[31:25] == 7'h00 || instr[31:25] == 7'h20) begin
                  rd_we = 1'b1; rd_val = alu(rv1, rv2, f3, instr[30]);
                end
      OP_SYS:   if (csr_op) begin
                  rd_we = 1'b1; rd_val = csr_rd; csr_we = 1'b1;
                end else if (f3 == 3'd0 && csr_a == 12'h000) begin
                  do_ecall = 1'b1; pc_d = pc_q;
                end else if (f3 == 3'd0 && csr_a == 12'h302) begin
                  pc_d = mepc_q;
                end
      default: ;
    endcase
    if (rd == 5'd0) rd_we = 1'b0;
  end

  always_ff @(posedge clk27MHz or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      mepc_q  <= '0;
      mtvec_q <= '0;
      exit_q  <= 1'b0;
      led_q   <= '0;
    end else if (!exit_q) begin
      pc_q <= pc_d;
      if (rd_we) rf_q[rd] <= rd_val;
      if (csr_we && csr_a == 12'h341) mepc_q  <= csr_nv;
      if (csr_we && csr_a == 12'h305) mtvec_q <= csr_nv;
      if (do_ecall) exit_q <= 1'b1;
      if (led_wr) led_q <= rv2[5:0];
    end
  end

  always_ff @(posedge clk27MHz) begin
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (wmask[b]) ram[widx][8*b +: 8] <= wdata[8*b +: 8];
  end

  // Frame bits shift out at the start of each bit period; bitn_q==10 is the extra cycle
  // that keeps busy high until the stop bit has fully elapsed.
  always_ff @(posedge clk27MHz or negedge rst_n) begin
    if (!rst_n) begin
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      shift_q <= '1;
      bitn_q  <= '0;
      baud_q  <= '0;
    end else if (tx_wr) begin
      busy_q  <= 1'b1;
      shift_q <= {1'b1, rv2[7:0], 1'b0};
      bitn_q  <= '0;
      baud_q  <= '0;
    end else if (busy_q) begin
      if (bitn_q == 4'd10) begin
        busy_q <= 1'b0;
      end else begin
        if (baud_q == '0) begin
          tx_q    <= shift_q[0];
          shift_q <= {1'b1, shift_q[9:1]};
        end
        if (baud_q == BIT_LAST) begin
          baud_q <= '0;
          bitn_q <= bitn_q + 4'd1;
        end else begin
          baud_q <= baud_q + 32'd1;
        end
      end
    end
  end

  logic unused;
  assign unused  = uart_rx;

  assign uart_tx = tx_q;
  assign exit    = exit_q;
  assign led     = ~led_q;
  assign gp      = rf_q[3];
endmodule

// File: tb/tb_main_soc.sv
// Bench for main_soc: hand-assembled programs are preloaded into RAM, expected x3 values
// and UART bits are queued up front and compared as the core produces them.
module tb_main_soc;
  localparam int BITP = 234;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JALR = 7'h67, LD = 7'h03,
                         OPI = 7'h13, SYS = 7'h73;
  localparam logic [31:0] ECALL = 32'h0000_0073, MRET = 32'h3020_0073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_tx, ex;
  logic [5:0]  led;
  logic [31:0] gp;

  main_soc dut (
    .clk27MHz (clk),
    .rst_n    (rst_n),
    .uart_rx  (1'b0),
    .uart_tx  (uart_tx),
    .exit     (ex),
    .led      (led),
    .gp       (gp)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] uart_q[$];
  logic [31:0] prog[$];
  logic        mon_en = 1'b0;
  logic [31:0] gp_prev = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ei(int imm, int rd, int rs1, int f3, logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] es(int imm, int rs1, int rs2, int f3);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] eb(int imm, int rs1, int rs2, int f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] eu(int imm20, int rd, logic [6:0] op);
    logic [31:0] v;
    v = imm20;
    return {v[19:0], 5'(rd), op};
  endfunction
  function automatic logic [31:0] ej(int imm, int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
  endfunction
  function automatic logic [31:0] er(int f7, int rd, int rs1, int rs2, int f3);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return ei(imm, rd, rs1, 0, OPI);
  endfunction

  // Every change of gp while running must be the next queued value.
  always @(negedge clk) begin
    if (!rst_n || !mon_en) gp_prev = gp;
    else if (gp !== gp_prev) begin
      if (exp_q.size() == 0) chk("gp_spurious", gp, gp_prev);
      else chk("gp_seq", gp, exp_q.pop_front());
      gp_prev = gp;
    end
  end

  task automatic start_prog();
    rst_n  = 1'b0;
    mon_en = 1'b0;
    for (int i = 0; i < 128; i++) dut.ram[i] = (i < prog.size()) ? prog[i] : 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic wait_exit(input int max_cyc, output int cyc);
    cyc = 0;
    while (ex !== 1'b1 && cyc < max_cyc) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("exit_seen", ex, 1);
  endtask

  task automatic uart_check();
    int   n;
    logic saw_low;
    n = 0;
    while (uart_tx !== 1'b0 && n < 6000) begin @(negedge clk); n++; end
    chk("uart_start", uart_tx, uart_q.pop_front());
    n = 0;
    while (uart_tx === 1'b0 && n < 1000) begin @(negedge clk); n++; end
    chk("uart_bitlen", n, BITP);
    repeat (BITP / 2) @(negedge clk);
    for (int k = 1; k < 10; k++) begin
      chk("uart_bit", uart_tx, uart_q.pop_front());
      repeat (BITP) @(negedge clk);
    end
    saw_low = 1'b0;
    repeat (2500) begin
      @(negedge clk);
      if (uart_tx === 1'b0) saw_low = 1'b1;
    end
    chk("uart_no_2nd_frame", saw_low, 0);
  endtask

  initial begin
    int         cyc;
    logic [9:0] frame;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_exit", ex, 0);
    chk("rst_gp", gp, 0);
    chk("rst_led", led, 6'h3F);
    chk("rst_tx", uart_tx, 1);

    // pass path
    prog = '{addi(3, 0, 1), ECALL};
    exp_q.push_back(32'd1);
    start_prog();
    wait_exit(10, cyc);
    chk("pass_exit_edge", cyc, 2);
    chk("pass_sb_empty", exp_q.size(), 0);
    repeat (100) @(negedge clk);
    chk("pass_exit_hold", ex, 1);
    chk("pass_gp_hold", gp, 1);

    // loads/stores, byte lanes and address wrap
    prog = '{eu(32'h80000, 5, LUI), addi(5, 5, 32'hF0), addi(6, 0, 32'h100), es(0, 6, 5, 2),
             ei(0, 3, 6, 0, LD), ei(0, 3, 6, 5, LD), ei(3, 3, 6, 4, LD), ei(2, 3, 6, 1, LD),
             addi(7, 0, 32'h55), es(1, 6, 7, 0), ei(0, 3, 6, 2, LD), es(2, 6, 7, 1),
             ei(0, 3, 6, 2, LD), eu(4, 8, LUI), er(0, 8, 8, 6, 0), es(0, 8, 0, 0),
             ei(0, 3, 6, 2, LD), ECALL};
    exp_q = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'h0000_0080, 32'hFFFF_8000,
              32'h8000_55F0, 32'h0055_55F0, 32'h0055_5500};
    start_prog();
    wait_exit(100, cyc);
    chk("mem_sb_empty", exp_q.size(), 0);
    chk("mem_gp_not_pass", (gp == 32'd1), 0);

    // ALU, branches, jumps, CSR and MRET
    prog = '{addi(1, 0, -8), ei(32'h401, 3, 1, 5, OPI), ei(28, 3, 1, 5, OPI),
             er(0, 3, 1, 0, 2), er(0, 3, 1, 0, 3), addi(2, 0, 3), eb(8, 2, 0, 1),
             addi(3, 0, 99), eb(8, 2, 0, 0), addi(3, 0, 7), ej(8, 3), addi(3, 0, 99),
             addi(4, 0, 32'h41), ei(0, 3, 4, 0, JALR), addi(3, 0, 99), addi(3, 0, 98),
             addi(5, 0, 32'h60), ei(32'h341, 0, 5, 1, SYS), ei(32'h341, 3, 0, 2, SYS), MRET,
             addi(3, 0, 97), 32'h0, 32'h0, 32'h0,
             er(0, 3, 2, 2, 1), er(32, 3, 0, 2, 0), addi(0, 0, 5), er(0, 3, 0, 0, 0),
             eu(1, 3, AUIPC), ECALL};
    exp_q = '{32'hFFFF_FFFC, 32'h0000_000F, 32'h1, 32'h0, 32'h7, 32'h2C, 32'h38,
              32'h60, 32'h18, 32'hFFFF_FFFD, 32'h0, 32'h1070};
    start_prog();
    wait_exit(200, cyc);
    chk("ctl_sb_empty", exp_q.size(), 0);

    // UART frame, busy flag, dropped second write, LED register
    prog = '{eu(32'hF0000, 10, LUI), addi(11, 0, 32'h41), es(0, 10, 11, 2),
             ei(4, 3, 10, 2, LD), addi(12, 0, 32'h42), es(0, 10, 12, 2),
             addi(13, 0, 32'h2A), es(8, 10, 13, 2), ei(8, 3, 10, 2, LD),
             ei(4, 14, 10, 2, LD), eb(-4, 14, 0, 1), ei(4, 3, 10, 2, LD), ECALL};
    exp_q = '{32'h1, 32'h2A, 32'h0};
    frame = {1'b1, 8'h41, 1'b0};
    for (int k = 0; k < 10; k++) uart_q.push_back({31'b0, frame[k]});
    fork
      begin
        start_prog();
        wait_exit(4000, cyc);
      end
      uart_check();
    join
    chk("uart_sb_empty", exp_q.size(), 0);
    chk("led_val", led, 6'h15);

    // asynchronous reset in the middle of a frame
    prog = '{eu(32'hF0000, 10, LUI), addi(11, 0, 32'h41), es(0, 10, 11, 2),
             addi(13, 0, 32'h2A), es(8, 10, 13, 2), ej(0, 0)};
    exp_q.delete();
    start_prog();
    repeat (500) @(negedge clk);
    chk("midframe_tx_low", uart_tx, 0);
    chk("midframe_led", led, 6'h15);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_tx", uart_tx, 1);
    chk("abort_led", led, 6'h3F);
    chk("abort_exit", ex, 0);
    chk("abort_gp", gp, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
